// File: rtl/data_mem_mmio.sv
// Data-memory responder for the core's load/store port: word RAM with sub-word access,
// plus a small MMIO window holding GPIO and a compare timer with interrupt.
module data_mem_mmio #(
    parameter int          RAM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic        timer_irq,
    output logic        mis_err
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    localparam logic [4:0] OFF_GPIO_OUT = 5'h00;
    localparam logic [4:0] OFF_GPIO_IN  = 5'h04;
    localparam logic [4:0] OFF_COUNT    = 5'h08;
    localparam logic [4:0] OFF_CMP      = 5'h0C;
    localparam logic [4:0] OFF_CTRL     = 5'h10;

    logic [31:0] mem [RAM_WORDS];

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [4:0]    mmio_off;

    logic is_b, is_h, is_w, load_ok, store_ok;
    logic misaligned, ram_hit, mmio_hit, mmio_acc;
    logic ram_we, mmio_we;
    logic [3:0]  byte_en;
    logic [31:0] wr_lanes;
    logic [31:0] ram_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        match;

    logic [31:0] gpio_out_q, gpio_out_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        flag_q, flag_d;
    logic        ie_q, ie_d;
    logic        mis_err_q, mis_err_d;

    assign word_idx = Mem_WrAddr[AW+1:2];
    assign lane     = Mem_WrAddr[1:0];
    assign mmio_off = Mem_WrAddr[4:0];

    always_comb begin
        is_b     = (funct3 == 3'b000) || (funct3 == 3'b100);
        is_h     = (funct3 == 3'b001) || (funct3 == 3'b101);
        is_w     = (funct3 == 3'b010);
        load_ok  = is_b || is_h || is_w;
        store_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);

        misaligned = (MemWrite || load_ok) &&
                     ((is_h && Mem_WrAddr[0]) || (is_w && (Mem_WrAddr[1:0] != 2'b00)));

        ram_hit  = (Mem_WrAddr < RAM_BYTES);
        mmio_hit = (Mem_WrAddr[31:5] == MMIO_BASE[31:5]) &&
                   ((mmio_off == OFF_GPIO_OUT) || (mmio_off == OFF_GPIO_IN) ||
                    (mmio_off == OFF_COUNT)    || (mmio_off == OFF_CMP)     ||
                    (mmio_off == OFF_CTRL));
        // MMIO registers are word-only; narrower accesses fall through as no-ops
        mmio_acc = mmio_hit && is_w;

        ram_we  = MemWrite && ram_hit && store_ok && !misaligned;
        mmio_we = MemWrite && mmio_acc && !misaligned;

        byte_en  = 4'b0000;
        wr_lanes = Mem_WrData;
        if (funct3 == 3'b000) begin
            byte_en  = 4'b0001 << lane;
            wr_lanes = {4{Mem_WrData[7:0]}};
        end else if (funct3 == 3'b001) begin
            byte_en  = lane[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{Mem_WrData[15:0]}};
        end else if (funct3 == 3'b010) begin
            byte_en  = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        ram_word = mem[word_idx];
        byte_sel = ram_word[8*lane +: 8];
        half_sel = lane[1] ? ram_word[31:16] : ram_word[15:0];

        ReadData = 32'h0;
        if (!misaligned) begin
            if (ram_hit) begin
                case (funct3)
                    3'b000:  ReadData = {{24{byte_sel[7]}}, byte_sel};
                    3'b100:  ReadData = {24'h0, byte_sel};
                    3'b001:  ReadData = {{16{half_sel[15]}}, half_sel};
                    3'b101:  ReadData = {16'h0, half_sel};
                    3'b010:  ReadData = ram_word;
                    default: ReadData = 32'h0;
                endcase
            end else if (mmio_acc) begin
                case (mmio_off)
                    OFF_GPIO_OUT: ReadData = gpio_out_q;
                    OFF_GPIO_IN:  ReadData = gpio_in;
                    OFF_COUNT:    ReadData = count_q;
                    OFF_CMP:      ReadData = cmp_q;
                    OFF_CTRL:     ReadData = {29'h0, ie_q, flag_q, en_q};
                    default:      ReadData = 32'h0;
                endcase
            end
        end
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        count_d    = count_q;
        cmp_d      = cmp_q;
        en_d       = en_q;
        flag_d     = flag_q;
        ie_d       = ie_q;
        mis_err_d  = mis_err_q || misaligned;

        match = en_q && (count_q == cmp_q);
        if (match) begin
            count_d = 32'h0;
        end else if (en_q) begin
            count_d = count_q + 32'd1;
        end

        if (mmio_we) begin
            case (mmio_off)
                OFF_GPIO_OUT: gpio_out_d = Mem_WrData;
                OFF_COUNT:    count_d    = Mem_WrData;
                OFF_CMP:      cmp_d      = Mem_WrData;
                OFF_CTRL: begin
                    en_d = Mem_WrData[0];
                    ie_d = Mem_WrData[2];
                    if (Mem_WrData[1]) begin
                        flag_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // a match in the same cycle wins over the software clear
        if (match) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out_q <= 32'h0;
            count_q    <= 32'h0;
            cmp_q      <= 32'h0;
            en_q       <= 1'b0;
            flag_q     <= 1'b0;
            ie_q       <= 1'b0;
            mis_err_q  <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            en_q       <= en_d;
            flag_q     <= flag_d;
            ie_q       <= ie_d;
            mis_err_q  <= mis_err_d;
        end
    end

    assign gpio_out  = gpio_out_q;
    assign timer_irq = flag_q && ie_q;
    assign mis_err   = mis_err_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM sub-word access, alignment, GPIO, timer, decode, reset.
module tb_data_mem_mmio;

    localparam logic [31:0] MB         = 32'hFFFF_0000;
    localparam logic [31:0] A_GPIO_OUT = MB + 32'h00;
    localparam logic [31:0] A_GPIO_IN  = MB + 32'h04;
    localparam logic [31:0] A_COUNT    = MB + 32'h08;
    localparam logic [31:0] A_CMP      = MB + 32'h0C;
    localparam logic [31:0] A_CTRL     = MB + 32'h10;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic [2:0] F_NONE = 3'b011;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [2:0]  funct3;
    logic [31:0] ReadData;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        timer_irq;
    logic        mis_err;

    int n_vec;
    int n_err;
    logic [31:0] rd;

    data_mem_mmio #(
        .RAM_WORDS(256),
        .MMIO_BASE(32'hFFFF_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Mem_WrAddr(Mem_WrAddr),
        .Mem_WrData(Mem_WrData),
        .funct3    (funct3),
        .ReadData  (ReadData),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq),
        .mis_err   (mis_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // drive during the low phase, commit at the next rising edge, then go idle
    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        @(negedge clk);
        MemWrite   = 1'b1;
        Mem_WrAddr = addr;
        Mem_WrData = data;
        funct3     = f3;
        @(posedge clk);
        #1;
        MemWrite   = 1'b0;
        Mem_WrAddr = 32'h0;
        Mem_WrData = 32'h0;
        funct3     = F_NONE;
    endtask

    task automatic load(input logic [31:0] addr, input logic [2:0] f3, output logic [31:0] data);
        MemWrite   = 1'b0;
        Mem_WrAddr = addr;
        funct3     = f3;
        #1;
        data = ReadData;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b0;
        MemWrite   = 1'b0;
        Mem_WrAddr = 32'h0;
        Mem_WrData = 32'h0;
        funct3     = F_NONE;
        gpio_in    = 32'h0;
        #12;
        check_vec("rst_gpio_out", gpio_out, 32'h0);
        check_vec("rst_irq", {31'h0, timer_irq}, 32'h0);
        check_vec("rst_mis_err", {31'h0, mis_err}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // sub-word stores and loads
        store(32'h10, 32'h1122_3344, F_W);
        store(32'h11, 32'h0000_00AB, F_B);
        store(32'h12, 32'h0000_BEEF, F_H);
        load(32'h10, F_W, rd);  check_vec("lw_10", rd, 32'hBEEF_AB44);
        load(32'h11, F_B, rd);  check_vec("lb_11", rd, 32'hFFFF_FFAB);
        load(32'h11, F_BU, rd); check_vec("lbu_11", rd, 32'h0000_00AB);
        load(32'h12, F_HU, rd); check_vec("lhu_12", rd, 32'h0000_BEEF);
        load(32'h12, F_H, rd);  check_vec("lh_12", rd, 32'hFFFF_BEEF);
        load(32'h10, F_B, rd);  check_vec("lb_10", rd, 32'h0000_0044);
        load(32'h10, 3'b110, rd); check_vec("undef_f3", rd, 32'h0);

        // GPIO and word-only MMIO
        gpio_in = 32'h0000_1234;
        store(A_GPIO_OUT, 32'hA5A5_A5A5, F_W);
        check_vec("gpio_out", gpio_out, 32'hA5A5_A5A5);
        load(A_GPIO_IN, F_W, rd); check_vec("gpio_in_rd", rd, 32'h0000_1234);
        store(A_GPIO_OUT, 32'h0000_00FF, F_B);
        check_vec("gpio_sb_ign", gpio_out, 32'hA5A5_A5A5);
        store(A_GPIO_OUT, 32'h0000_FFFF, F_H);
        check_vec("gpio_sh_ign", gpio_out, 32'hA5A5_A5A5);
        store(A_GPIO_IN, 32'hFFFF_FFFF, F_W);
        load(A_GPIO_IN, F_W, rd); check_vec("gpio_in_ro", rd, 32'h0000_1234);
        load(A_GPIO_OUT, F_B, rd); check_vec("mmio_lb_zero", rd, 32'h0);
        check_vec("mmio_no_mis", {31'h0, mis_err}, 32'h0);

        // unmapped addresses
        store(32'h0, 32'hCAFE_F00D, F_W);
        store(32'h400, 32'hDEAD_BEEF, F_W);
        store(MB + 32'h14, 32'h0000_0007, F_W);
        load(32'h400, F_W, rd);       check_vec("unmap_ram_rd", rd, 32'h0);
        load(MB + 32'h14, F_W, rd);   check_vec("unmap_mmio_rd", rd, 32'h0);
        load(32'h0, F_W, rd);         check_vec("unmap_no_alias", rd, 32'hCAFE_F00D);
        load(A_CTRL, F_W, rd);        check_vec("unmap_ctrl", rd, 32'h0);
        check_vec("unmap_gpio", gpio_out, 32'hA5A5_A5A5);

        // misalignment
        store(32'h20, 32'h5566_7788, F_W);
        check_vec("pre_mis", {31'h0, mis_err}, 32'h0);
        store(32'h21, 32'h0000_1234, F_H);
        check_vec("mis_set", {31'h0, mis_err}, 32'h1);
        store(32'h22, 32'h0BAD_0BAD, F_W);
        load(32'h20, F_W, rd);  check_vec("mis_ram_kept", rd, 32'h5566_7788);
        load(32'h21, F_H, rd);  check_vec("mis_lh_zero", rd, 32'h0);
        load(32'h21, F_B, rd);  check_vec("lb_21", rd, 32'h0000_0077);
        @(posedge clk); #1;
        check_vec("mis_sticky", {31'h0, mis_err}, 32'h1);

        // compare timer
        store(A_CMP, 32'd3, F_W);
        store(A_CTRL, 32'h5, F_W);
        load(A_COUNT, F_W, rd); check_vec("cnt_0", rd, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            load(A_COUNT, F_W, rd); check_vec($sformatf("cnt_%0d", i), rd, 32'(i));
            check_vec("irq_low", {31'h0, timer_irq}, 32'h0);
        end
        @(posedge clk);
        load(A_COUNT, F_W, rd); check_vec("cnt_wrap", rd, 32'd0);
        check_vec("irq_match", {31'h0, timer_irq}, 32'h1);
        load(A_CTRL, F_W, rd);  check_vec("ctrl_flag", rd, 32'h7);
        store(A_CTRL, 32'h7, F_W);
        check_vec("irq_w1c", {31'h0, timer_irq}, 32'h0);
        load(A_CTRL, F_W, rd);  check_vec("ctrl_w1c", rd, 32'h5);
        load(A_COUNT, F_W, rd); check_vec("cnt_after_w1c", rd, 32'd1);
        @(posedge clk);
        @(posedge clk);
        load(A_COUNT, F_W, rd); check_vec("cnt_pre_race", rd, 32'd3);
        store(A_CTRL, 32'h7, F_W);
        load(A_CTRL, F_W, rd);  check_vec("race_flag", rd, 32'h7);
        check_vec("race_irq", {31'h0, timer_irq}, 32'h1);
        load(A_COUNT, F_W, rd); check_vec("race_cnt", rd, 32'd0);
        store(A_COUNT, 32'h100, F_W);
        load(A_COUNT, F_W, rd); check_vec("cnt_write", rd, 32'h100);
        store(A_CTRL, 32'h0, F_W);
        load(A_COUNT, F_W, rd); check_vec("cnt_dis_edge", rd, 32'h101);
        load(A_CTRL, F_W, rd);  check_vec("ctrl_flag_kept", rd, 32'h2);
        check_vec("irq_ie_off", {31'h0, timer_irq}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        load(A_COUNT, F_W, rd); check_vec("cnt_frozen", rd, 32'h101);

        // asynchronous reset mid-run
        store(A_CMP, 32'd100, F_W);
        store(A_COUNT, 32'd5, F_W);
        store(A_CTRL, 32'h5, F_W);
        load(A_COUNT, F_W, rd); check_vec("pre_rst_cnt", rd, 32'd5);
        check_vec("pre_rst_irq", {31'h0, timer_irq}, 32'h1);
        reset = 1'b0;
        #1;
        check_vec("arst_gpio", gpio_out, 32'h0);
        check_vec("arst_irq", {31'h0, timer_irq}, 32'h0);
        check_vec("arst_mis", {31'h0, mis_err}, 32'h0);
        load(A_COUNT, F_W, rd); check_vec("arst_cnt", rd, 32'h0);
        load(A_CTRL, F_W, rd);  check_vec("arst_ctrl", rd, 32'h0);
        load(A_CMP, F_W, rd);   check_vec("arst_cmp", rd, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
- Responder end of the CPU data-memory port: the block the core's load/store interface talks to.
- Holds word-organised data RAM with sub-word store/load handling from funct3.
- Exposes memory-mapped GPIO and a compare timer with interrupt.
- Sits beside the core in the SoC top; funct3 is taken from Instr[14:12] there.

Parameters:
- RAM_WORDS, 256, data RAM depth in 32-bit words; byte range 0 .. RAM_WORDS*4-1; must be a power of 2.
- MMIO_BASE, 32'hFFFF_0000, base of the 5-register MMIO window; offsets 0x00-0x10.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  store strobe, valid for the current cycle.
- Mem_WrAddr  in  32  byte address for both loads and stores.
- Mem_WrData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ReadData  out  32  load data, combinational, extended per funct3.
- gpio_in  in  32  external inputs.
- gpio_out  out  32  GPIO output register.
- timer_irq  out  1  CTRL.flag & CTRL.ie.
- mis_err  out  1  sticky misaligned-access flag.

Behaviour:
- Reset (reset=0, async): gpio_out=0, COUNT=0, CMP=0, CTRL=0, mis_err=0, timer_irq=0. RAM contents are not reset.
- Decode:
  - RAM when addr < RAM_WORDS*4; word index addr[log2(RAM_WORDS)+1:2].
  - MMIO when addr[31:5]==MMIO_BASE[31:5] and addr[4:0] is one of 0x00, 0x04, 0x08, 0x0C, 0x10.
  - Everything else is unmapped: reads return 0, writes are ignored.
- Alignment: h needs addr[0]=0; w needs addr[1:0]=0. A misaligned access is one where MemWrite=1 or funct3 selects a load size, and the address violates these rules.
  - Misaligned store: suppressed.
  - Misaligned read: returns 0.
  - Either sets mis_err at the next edge; only reset clears mis_err.
- RAM stores (take effect at the rising edge when MemWrite=1):
  - sb writes lane addr[1:0] with WrData[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with WrData[15:0].
  - sw writes all 4 lanes.
  - funct3 values not listed above: store ignored.
- RAM loads are combinational from current address and array contents; read-during-write returns old data.
  - lb/lbu: selected byte, sign- or zero-extended.
  - lh/lhu: selected half, sign- or zero-extended.
  - lw: full word.
  - Undefined funct3: 0.
- MMIO registers accept word access only. sb/sh to MMIO: write ignored, read returns 0, mis_err not set.
  - 0x00 GPIO_OUT: RW.
  - 0x04 GPIO_IN: RO, reads gpio_in directly (no synchroniser here); writes ignored.
  - 0x08 COUNT: RW.
  - 0x0C CMP: RW.
  - 0x10 CTRL: bit0 en, bit1 flag, bit2 ie; other bits read 0.
    - Writes load en and ie.
    - Writing bit1=1 clears flag (W1C); writing bit1=0 leaves flag unchanged.
- Timer, each edge:
  - If en and COUNT==CMP: COUNT<=0 and flag<=1.
  - Else if en: COUNT<=COUNT+1, wrapping at 2^32.
  - Else: hold.
- Timer priorities:
  - A CPU write to COUNT beats increment/clear, but a match in that cycle still sets flag.
  - Flag set by a match beats a simultaneous W1C clear.
  - A CMP write takes effect for compare next cycle.
  - en written 0 freezes COUNT the next cycle.
- timer_irq is combinational from the register bits (no extra latency beyond the flag register).
- Load latency 0 cycles; store latency 1 edge.

Test Plan:
- Reset low mid-run with en=1, COUNT=5 -> gpio_out=0, COUNT=0, CTRL=0, timer_irq=0 immediately, without waiting for clk.
- sw 0x11223344 @0x10; sb 0xAB @0x11; sh 0xBEEF @0x12 -> lw @0x10 = 0xBEEFAB44; lb @0x11 = 0xFFFFFFAB; lbu @0x11 = 0x000000AB; lhu @0x12 = 0x0000BEEF.
- sh @0x21, then sw @0x22 -> RAM word 0x20 unchanged, lh @0x21 reads 0, mis_err=1 after the first edge and stays 1.
- sw 3 to CMP, sw 0x5 to CTRL (en, ie) -> COUNT 0,1,2,3, then flag=1 and timer_irq=1 with COUNT=0; sw 0x7 to CTRL -> flag clears, irq drops, unless a match lands in the same cycle (then flag stays 1).
- sw 0xA5A5A5A5 to GPIO_OUT with gpio_in=0x1234 -> gpio_out=0xA5A5A5A5 after the edge; lw GPIO_IN = 0x00001234; sb to GPIO_OUT leaves 0xA5A5A5A5.
- lw @MMIO_BASE+0x14 and lw @RAM_WORDS*4 -> ReadData=0; stores to either address change no state.
